// File: rtl/nlc_nch_horner.sv
// N-channel nonlinearity-correction engine: round-robin input arbitration, per-channel
// per-section calibration register file, and Horner polynomial evaluation on one shared multiplier.
module nlc_nch_horner #(
   parameter int NCH   = 4,
   parameter int XW    = 21,
   parameter int CW    = 48,
   parameter int FRAC  = 24,
   parameter int ORDER = 10,
   localparam int CHW  = $clog2(NCH),
   localparam int IW   = $clog2(ORDER + 3),
   localparam int AW   = CHW + 2 + IW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [NCH*XW-1:0]    x_adc,
   input  logic [XW-2:0]        section_limit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CHW-1:0]       out_ch,
   output logic signed [XW-1:0] x_lin,
   input  logic                 cfg_we,
   output logic                 cfg_ready,
   input  logic [AW-1:0]        cfg_addr,
   input  logic signed [CW-1:0] cfg_wdata
);

   typedef enum logic [2:0] {IDLE, SEL, SCALE, HORN, OUT} state_t;

   localparam logic [IW-1:0] IDX_TOP   = IW'(ORDER);
   localparam logic [IW-1:0] IDX_MEAN  = IW'(ORDER + 1);
   localparam logic [IW-1:0] IDX_RECIP = IW'(ORDER + 2);

   state_t state, state_nxt;

   logic signed [CW-1:0] rf [NCH][4][ORDER+3];

   logic [CHW-1:0]       ptr, grant, ch_reg;
   logic                 found, accept;
   logic signed [XW-1:0] x_reg;
   logic [1:0]           sec_reg, sec_c;
   logic signed [CW-1:0] xc, xs, acc;
   logic [IW-1:0]        k;

   logic [XW-1:0]          x_abs;
   logic                   over, pos;
   logic signed [CW-1:0]   mul_a, mul_b, acc_sh;
   logic signed [2*CW-1:0] prod, prod_sh;
   logic signed [2*CW:0]   hsum;

   logic [CHW-1:0] cfg_ch;
   logic [1:0]     cfg_sec;
   logic [IW-1:0]  cfg_idx;

   function automatic logic signed [CW-1:0] sat_cw(input logic signed [2*CW:0] v);
      if (v[2*CW:CW-1] == {(CW+2){v[2*CW]}})
         return v[CW-1:0];
      else if (v[2*CW])
         return {1'b1, {(CW-1){1'b0}}};
      else
         return {1'b0, {(CW-1){1'b1}}};
   endfunction

   function automatic logic signed [XW-1:0] sat_xw(input logic signed [CW-1:0] v);
      if (v[CW-1:XW-1] == {(CW-XW+1){v[CW-1]}})
         return v[XW-1:0];
      else if (v[CW-1])
         return {1'b1, {(XW-1){1'b0}}};
      else
         return {1'b0, {(XW-1){1'b1}}};
   endfunction

   // Round-robin search: first valid channel at or after the pointer wins
   always_comb begin
      logic [CHW:0] cand;
      found    = 1'b0;
      grant    = '0;
      in_ready = '0;
      cand     = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = {1'b0, ptr} + (CHW+1)'(i);
         if (cand >= (CHW+1)'(NCH))
            cand = cand - (CHW+1)'(NCH);
         if (!found && in_valid[cand[CHW-1:0]]) begin
            found = 1'b1;
            grant = cand[CHW-1:0];
         end
      end
      if (state == IDLE && found)
         in_ready[grant] = 1'b1;
   end

   assign accept = (state == IDLE) && found;

   // Section 1 and 2 straddle zero: zero itself counts as the non-positive side
   assign x_abs = x_reg[XW-1] ? (~x_reg + 1'b1) : x_reg;
   assign over  = x_abs > {1'b0, section_limit};
   assign pos   = !x_reg[XW-1] && (x_reg != '0);
   assign sec_c = pos ? (over ? 2'd3 : 2'd2) : (over ? 2'd0 : 2'd1);

   assign mul_a   = (state == SCALE) ? xc : acc;
   assign mul_b   = (state == SCALE) ? rf[ch_reg][sec_reg][IDX_RECIP] : xs;
   assign prod    = (2*CW)'(mul_a) * (2*CW)'(mul_b);
   assign prod_sh = prod >>> FRAC;
   assign hsum    = (2*CW+1)'(prod_sh) + (2*CW+1)'(rf[ch_reg][sec_reg][k]);
   assign acc_sh  = acc >>> FRAC;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SEL;
         SEL:     state_nxt = SCALE;
         SCALE:   state_nxt = HORN;
         HORN:    if (k == '0) state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         ch_reg  <= '0;
         x_reg   <= '0;
         sec_reg <= '0;
         xc      <= '0;
         xs      <= '0;
         acc     <= '0;
         k       <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  x_reg  <= x_adc[grant*XW +: XW];
                  ch_reg <= grant;
                  ptr    <= (grant == CHW'(NCH-1)) ? '0 : grant + 1'b1;
               end
            end
            SEL: begin
               sec_reg <= sec_c;
               xc      <= (CW'(x_reg) <<< FRAC) + rf[ch_reg][sec_c][IDX_MEAN];
            end
            SCALE: begin
               xs  <= sat_cw((2*CW+1)'(prod_sh));
               acc <= rf[ch_reg][sec_reg][IDX_TOP];
               k   <= IW'(ORDER - 1);
            end
            HORN: begin
               acc <= sat_cw(hsum);
               k   <= k - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cfg_ch  = cfg_addr[AW-1 -: CHW];
   assign cfg_sec = cfg_addr[IW +: 2];
   assign cfg_idx = cfg_addr[IW-1:0];

   // Config writes only land while idle so an evaluation always sees one consistent set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 4; s++)
               for (int i = 0; i < ORDER + 3; i++)
                  rf[c][s][i] <= '0;
      end else if (cfg_we && cfg_ready && int'(cfg_ch) < NCH && int'(cfg_idx) <= ORDER + 2) begin
         rf[cfg_ch][cfg_sec][cfg_idx] <= cfg_wdata;
      end
   end

   assign cfg_ready = (state == IDLE);
   assign out_valid = (state == OUT);
   assign x_lin     = out_valid ? sat_xw(acc_sh) : '0;
   assign out_ch    = out_valid ? ch_reg : '0;

endmodule

// File: doc/nlc_nch_horner.md
Name: nlc_nch_horner

Overview:
- Parametrised N-channel nonlinearity-correction (NLC) engine and successor of the single-channel NLC.
- Accepts ADC samples from NCH channels through per-channel valid/ready handshakes, with round-robin arbitration.
- Selects one of 4 calibration sections per sample, centres and scales the sample, and evaluates an ORDER-degree polynomial by time-multiplexed Horner iteration on one shared multiplier.
- Per-channel calibration constants live in an internal register file loaded through a config port, replacing the flat coefficient port list.

Parameters:
- NCH, 4, number of ADC channels (>=2).
- XW, 21, signed sample width for x_adc and x_lin.
- CW, 48, signed fixed-point width of coefficients, mean, reciprocal stdev and accumulator.
- FRAC, 24, fractional bits of all CW quantities (1.0 = 2^FRAC).
- ORDER, 10, polynomial degree (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NCH  per-channel sample valid.
- in_ready  out  NCH  per-channel accept.
- x_adc  in  NCH*XW  channel i sample at bits [i*XW +: XW], signed.
- section_limit  in  XW-1  unsigned |x| threshold, shared by all channels.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_ch  out  clog2(NCH)  channel tag of the result.
- x_lin  out  XW  corrected sample, signed.
- cfg_we  in  1  config write request.
- cfg_ready  out  1  config write accepted when high.
- cfg_addr  in  clog2(NCH)+2+IW  address {ch, sec, idx}, where IW = clog2(ORDER+3).
- cfg_wdata  in  CW  config data.

Behaviour:
- Reset (async): state IDLE; all outputs 0 except cfg_ready=1; round-robin pointer = channel 0 highest priority; register file cleared to 0.
- Register file: idx 0..ORDER holds coeff c[idx]; idx ORDER+1 holds neg_mean; idx ORDER+2 holds recip_stdev; any other idx is ignored.
- Config writes: a write occurs on cfg_we & cfg_ready. cfg_ready = (state==IDLE). Writes are never applied mid-evaluation.
- Arbitration: in IDLE, grant goes to the first valid channel at or after the pointer. in_ready[g]=1 for the granted channel only; all others are 0. in_ready may depend combinationally on in_valid; in_valid must not depend on in_ready.
- On accept: latch the sample and its channel, and set pointer = g+1 mod NCH.
- Sections (x = latched sample, signed):
  - sec3: x>0 and |x|>limit.
  - sec2: x>0 and |x|<=limit.
  - sec1: x<=0 and |x|<=limit.
  - sec0: x<=0 and |x|>limit.
- FSM (accept edge = cycle 0):
  - SEL (cycle 1): register the section; xc <= (sext(x) << FRAC) + neg_mean.
  - SCALE (cycle 2): xs <= sat_CW((xc*recip_stdev) >>> FRAC); acc <= c[ORDER]; k <= ORDER-1.
  - HORN (cycles 3..ORDER+2): acc <= sat_CW(((acc*xs) >>> FRAC) + c[k]); k decrements; exit to OUT after k=0.
  - OUT: out_valid=1; x_lin = sat_XW(acc >>> FRAC); out_ch = channel.
- Arithmetic: >>> is arithmetic shift (floor). Each sat clamps to the signed range of the target width. The full 2*CW product is kept before shifting.
- Latency: out_valid rises in cycle ORDER+3 (13 at defaults).
- Output hold: out_valid, x_lin and out_ch hold stable until out_ready. On out_valid & out_ready, return to IDLE the next cycle. Peak throughput is 1 sample per ORDER+4 cycles.
- Simultaneous in_valid on several channels: one grant per IDLE cycle; unserved channels keep in_valid asserted.
- Reset mid-operation: return immediately to the reset state. The pending sample is discarded and no out_valid is produced.

Test Plan:
- Identity: for all 4 sections of ch0 set c1=2^24, other coeffs 0, neg_mean=0, recip=2^24. Send x=1000 -> x_lin=1000 and out_ch=0, 13 cycles after the accept edge. Send x=-1000 -> -1000.
- Sections: c0 = (sec+1)<<24, other coeffs 0, limit=100. Send x=-200,-50,0,50,100,101 -> x_lin=1,2,2,3,3,4.
- Centre/scale: c1=2^24, neg_mean=-2<<24, recip=2^23 (0.5). Send x=6 -> 2. With c2=2^24 only and identity mean/stdev, send x=3 -> 9.
- Saturation: c2=c1=2^24, identity mean/stdev. Send x=1048575 -> x_lin=1048575 (XW max). Send x=-1048576 with c1=2^24, c0=-2^24 -> -1048576 (clamped).
- Arbitration/backpressure: all 4 in_valid high together -> served order 0,1,2,3. Then raise ch2 and ch0 -> order 0,2. Hold out_ready low for 5 cycles -> x_lin/out_ch stay stable, no new in_ready.
- Reset/config: assert reset in HORN -> out_valid=0 next cycle and no stale result. Without reconfiguring, send x=500 -> x_lin=0. cfg_we during HORN -> cfg_ready=0 and the register file is unchanged.
